wb_arbiter: RTL and testbench

Writeback arbiter that sits directly upstream of the register file and drives its write port (ena/adr/data).
- Merges two result streams into the single regfile write port:
  - the ALU result stream, which cannot be stalled;
  - the memory-load response stream, which has backpressure.
- Buffers load responses in a small FIFO so an ALU result and a load result arriving together are both written.
- Kills stale load results that a younger ALU write has overtaken.
- Keeps a per-register pending-load scoreboard for the issue stage.

---
 rtl/wb_arbiter.sv | 129 ++++++++++++
 tb/tb_wb_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the unstallable ALU result stream and the
// backpressured load-response stream onto the single register-file write
// port. Load responses that lose arbitration wait in a small FIFO; those
// overtaken by a younger ALU write to the same register are dropped. A
// per-register busy vector tells the issue stage which loads are in flight.
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 3,
    parameter int DW    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic                   alu_vld_i,
    input  logic [AW-1:0]          alu_adr_i,
    input  logic [DW-1:0]          alu_data_i,
    input  logic                   mem_vld_i,
    input  logic [AW-1:0]          mem_adr_i,
    input  logic [DW-1:0]          mem_data_i,
    output logic                   mem_rdy_o,
    input  logic                   ld_issue_i,
    input  logic [AW-1:0]          ld_issue_adr_i,
    output logic [2**AW-1:0]       busy_o,
    output logic                   wr_ena_o,
    output logic [AW-1:0]          wr_adr_o,
    output logic [DW-1:0]          wr_data_o,
    output logic [$clog2(DEPTH):0] fifo_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int NR = 2**AW;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    // Load-response FIFO storage; kill marks an entry overtaken by an ALU write
    logic [AW-1:0]    fifo_adr  [DEPTH];
    logic [DW-1:0]    fifo_data [DEPTH];
    logic [DEPTH-1:0] fifo_kill;
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [PW:0]      cnt;

    logic             mem_acc, fifo_ne, pop, byp, push;
    logic             sel_vld_p0;
    logic [AW-1:0]    sel_adr_p0;
    logic [DW-1:0]    sel_data_p0;
    logic [NR-1:0]    busy_clr, busy_set;

    // Ready depends only on the registered count, never on inputs
    assign mem_rdy_o  = (cnt < FULL_CNT);
    assign fifo_cnt_o = cnt;

    assign mem_acc = mem_vld_i && mem_rdy_o;
    assign fifo_ne = (cnt != '0);
    assign pop     = !alu_vld_i && fifo_ne;
    assign byp     = !alu_vld_i && !fifo_ne && mem_acc;
    assign push    = mem_acc && !byp;

    // ---- stage p0: pick the next write source and the busy-vector updates
    // Priority ALU > FIFO head > bypass; a response leaving clears its busy bit
    always_comb begin
        sel_vld_p0  = 1'b0;
        sel_adr_p0  = '0;
        sel_data_p0 = '0;
        busy_clr    = '0;
        busy_set    = '0;
        if (alu_vld_i) begin
            sel_vld_p0  = 1'b1;
            sel_adr_p0  = alu_adr_i;
            sel_data_p0 = alu_data_i;
        end else if (pop) begin
            sel_vld_p0  = !fifo_kill[rd_ptr];
            sel_adr_p0  = fifo_adr[rd_ptr];
            sel_data_p0 = fifo_data[rd_ptr];
            busy_clr[fifo_adr[rd_ptr]] = 1'b1;
        end else if (byp) begin
            sel_vld_p0  = 1'b1;
            sel_adr_p0  = mem_adr_i;
            sel_data_p0 = mem_data_i;
            busy_clr[mem_adr_i] = 1'b1;
        end
        if (ld_issue_i) begin
            busy_set[ld_issue_adr_i] = 1'b1;
        end
    end

    // Entry payload and kill marking; a same-cycle push overrides the sweep
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_vld_i && (fifo_adr[i] == alu_adr_i)) begin
                fifo_kill[i] <= 1'b1;
            end
        end
        if (push) begin
            fifo_adr[wr_ptr]  <= mem_adr_i;
            fifo_data[wr_ptr] <= mem_data_i;
            fifo_kill[wr_ptr] <= alu_vld_i && (mem_adr_i == alu_adr_i);
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end

    // ---- stage p1: registered write port and busy vector (set beats clear)
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ena_o  <= 1'b0;
            wr_adr_o  <= '0;
            wr_data_o <= '0;
            busy_o    <= '0;
        end else begin
            wr_ena_o <= sel_vld_p0;
            if (sel_vld_p0) begin
                wr_adr_o  <= sel_adr_p0;
                wr_data_o <= sel_data_p0;
            end
            busy_o <= (busy_o & ~busy_clr) | busy_set;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter. Accepted load responses are queued
// in issue order; ALU writes are expected exactly one cycle after they are
// driven, and load writes must appear in FIFO order, skipping any response
// that a later ALU write to the same register has overtaken.
module tb_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        alu_vld_i, mem_vld_i, ld_issue_i;
    logic [2:0]  alu_adr_i, mem_adr_i, ld_issue_adr_i;
    logic [15:0] alu_data_i, mem_data_i;
    logic        mem_rdy_o, wr_ena_o;
    logic [7:0]  busy_o;
    logic [2:0]  wr_adr_o;
    logic [15:0] wr_data_o;
    logic [2:0]  fifo_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        kill;
        logic [2:0]  adr;
        logic [15:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        alu_prev = 1'b0;
    logic [2:0]  alu_prev_adr = '0;
    logic [15:0] alu_prev_data = '0;
    logic [15:0] rf_m [8];

    wb_arbiter #(.DEPTH(4), .AW(3), .DW(16)) dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .alu_vld_i     (alu_vld_i),
        .alu_adr_i     (alu_adr_i),
        .alu_data_i    (alu_data_i),
        .mem_vld_i     (mem_vld_i),
        .mem_adr_i     (mem_adr_i),
        .mem_data_i    (mem_data_i),
        .mem_rdy_o     (mem_rdy_o),
        .ld_issue_i    (ld_issue_i),
        .ld_issue_adr_i(ld_issue_adr_i),
        .busy_o        (busy_o),
        .wr_ena_o      (wr_ena_o),
        .wr_adr_o      (wr_adr_o),
        .wr_data_o     (wr_data_o),
        .fifo_cnt_o    (fifo_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alu_vld_i = 1'b0; alu_adr_i = '0; alu_data_i = '0;
        mem_vld_i = 1'b0; mem_adr_i = '0; mem_data_i = '0;
        ld_issue_i = 1'b0; ld_issue_adr_i = '0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Output monitor and expectation tracker, sampled mid-cycle
    initial begin
        for (int r = 0; r < 8; r++) rf_m[r] = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_n) begin
                mq.delete();
                alu_prev = 1'b0;
            end else begin
                if (wr_ena_o) begin
                    if (alu_prev) begin
                        chk("alu_wr_adr", 32'(wr_adr_o), 32'(alu_prev_adr));
                        chk("alu_wr_data", 32'(wr_data_o), 32'(alu_prev_data));
                    end else begin
                        while (mq.size() > 0 && mq[0].kill) void'(mq.pop_front());
                        if (mq.size() == 0) begin
                            chk("spurious_wr", 32'(wr_ena_o), 32'(0));
                        end else begin
                            ent_t e;
                            e = mq.pop_front();
                            chk("ld_wr_adr", 32'(wr_adr_o), 32'(e.adr));
                            chk("ld_wr_data", 32'(wr_data_o), 32'(e.data));
                        end
                    end
                    rf_m[wr_adr_o] = wr_data_o;
                end else if (alu_prev) begin
                    chk("alu_wr_missing", 32'(wr_ena_o), 32'(1));
                end
                if (ld_issue_i && busy_o[ld_issue_adr_i] &&
                    !(mem_vld_i && mem_rdy_o && mem_adr_i == ld_issue_adr_i)) begin
                    $error("load issued to busy register %0d", ld_issue_adr_i);
                end
                if (alu_vld_i) begin
                    foreach (mq[i]) if (mq[i].adr == alu_adr_i) mq[i].kill = 1'b1;
                end
                if (mem_vld_i && mem_rdy_o) begin
                    mq.push_back({alu_vld_i && (alu_adr_i == mem_adr_i), mem_adr_i, mem_data_i});
                end
                alu_prev      = alu_vld_i;
                alu_prev_adr  = alu_adr_i;
                alu_prev_data = alu_data_i;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int madr;
        int live;
        logic acc;
        idle();
        rst_n = 1'b0;
        tick(); tick();
        chk("rst_wr_ena", 32'(wr_ena_o), 32'(0));
        chk("rst_wr_adr", 32'(wr_adr_o), 32'(0));
        chk("rst_wr_data", 32'(wr_data_o), 32'(0));
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_cnt", 32'(fifo_cnt_o), 32'(0));
        chk("rst_rdy", 32'(mem_rdy_o), 32'(1));
        rst_n = 1'b1;
        tick();

        // Bypass into an idle block
        mem_vld_i = 1'b1; mem_adr_i = 3'd2; mem_data_i = 16'h1234;
        tick(); idle();
        chk("byp_ena", 32'(wr_ena_o), 32'(1));
        chk("byp_adr", 32'(wr_adr_o), 32'(2));
        chk("byp_data", 32'(wr_data_o), 32'h1234);
        chk("byp_cnt", 32'(fifo_cnt_o), 32'(0));
        tick();

        // ALU and load in the same cycle
        alu_vld_i = 1'b1; alu_adr_i = 3'd1; alu_data_i = 16'hAAAA;
        mem_vld_i = 1'b1; mem_adr_i = 3'd5; mem_data_i = 16'h5555;
        tick(); idle();
        chk("col_alu_adr", 32'(wr_adr_o), 32'(1));
        chk("col_alu_data", 32'(wr_data_o), 32'hAAAA);
        chk("col_cnt", 32'(fifo_cnt_o), 32'(1));
        tick();
        chk("col_ld_ena", 32'(wr_ena_o), 32'(1));
        chk("col_ld_adr", 32'(wr_adr_o), 32'(5));
        chk("col_ld_data", 32'(wr_data_o), 32'h5555);
        tick();

        // Fill to full under ALU pressure, then drain in order
        madr = 0;
        for (int i = 0; i < 6; i++) begin
            alu_vld_i = 1'b1; alu_adr_i = 3'd7; alu_data_i = 16'(16'h7000 + i);
            mem_vld_i = 1'b1; mem_adr_i = 3'(madr); mem_data_i = 16'(16'h5000 + madr);
            acc = mem_rdy_o;
            if (i == 4) chk("full_rdy", 32'(mem_rdy_o), 32'(0));
            tick();
            if (acc) madr++;
        end
        chk("full_accepts", 32'(madr), 32'(4));
        chk("full_cnt", 32'(fifo_cnt_o), 32'(4));
        alu_vld_i = 1'b0;
        for (int i = 0; i < 20 && madr < 6; i++) begin
            mem_vld_i = 1'b1; mem_adr_i = 3'(madr); mem_data_i = 16'(16'h5000 + madr);
            acc = mem_rdy_o;
            tick();
            if (acc) madr++;
        end
        idle();
        chk("drain_accepts", 32'(madr), 32'(6));
        repeat (8) tick();
        chk("drain_cnt", 32'(fifo_cnt_o), 32'(0));
        chk("drain_r5", 32'(rf_m[5]), 32'h5005);
        chk("drain_r7", 32'(rf_m[7]), 32'h7005);

        // Stale load killed by a younger ALU write
        ld_issue_i = 1'b1; ld_issue_adr_i = 3'd3;
        tick(); idle();
        chk("kill_busy_set", 32'(busy_o[3]), 32'(1));
        alu_vld_i = 1'b1; alu_adr_i = 3'd6; alu_data_i = 16'h0006;
        mem_vld_i = 1'b1; mem_adr_i = 3'd3; mem_data_i = 16'hBEEF;
        tick(); idle();
        chk("kill_cnt", 32'(fifo_cnt_o), 32'(1));
        alu_vld_i = 1'b1; alu_adr_i = 3'd3; alu_data_i = 16'h0001;
        tick(); idle();
        chk("kill_busy_hold", 32'(busy_o[3]), 32'(1));
        chk("kill_alu_data", 32'(wr_data_o), 32'h0001);
        tick();
        chk("kill_drop", 32'(wr_ena_o), 32'(0));
        chk("kill_busy_clr", 32'(busy_o[3]), 32'(0));
        chk("kill_cnt_empty", 32'(fifo_cnt_o), 32'(0));
        tick();
        chk("kill_r3", 32'(rf_m[3]), 32'h0001);

        // Busy set and clear in the same cycle
        ld_issue_i = 1'b1; ld_issue_adr_i = 3'd4;
        tick(); idle();
        mem_vld_i = 1'b1; mem_adr_i = 3'd4; mem_data_i = 16'h4444;
        ld_issue_i = 1'b1; ld_issue_adr_i = 3'd4;
        tick(); idle();
        chk("sc_wr_adr", 32'(wr_adr_o), 32'(4));
        chk("sc_busy", 32'(busy_o[4]), 32'(1));
        tick();
        chk("sc_busy_hold", 32'(busy_o[4]), 32'(1));
        mem_vld_i = 1'b1; mem_adr_i = 3'd4; mem_data_i = 16'h4445;
        tick(); idle();
        chk("sc_busy_clr", 32'(busy_o[4]), 32'(0));
        tick();

        // Reset while three responses are queued
        ld_issue_i = 1'b1; ld_issue_adr_i = 3'd6;
        for (int i = 0; i < 3; i++) begin
            alu_vld_i = 1'b1; alu_adr_i = 3'd7; alu_data_i = 16'(16'h7100 + i);
            mem_vld_i = 1'b1; mem_adr_i = 3'(i); mem_data_i = 16'(16'h6000 + i);
            tick();
            ld_issue_i = 1'b0;
        end
        chk("mid_cnt", 32'(fifo_cnt_o), 32'(3));
        chk("mid_busy", 32'(busy_o[6]), 32'(1));
        idle();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ena", 32'(wr_ena_o), 32'(0));
        chk("mid_rst_busy", 32'(busy_o), 32'(0));
        chk("mid_rst_cnt", 32'(fifo_cnt_o), 32'(0));
        chk("mid_rst_rdy", 32'(mem_rdy_o), 32'(1));
        tick(); tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("post_rst_cnt", 32'(fifo_cnt_o), 32'(0));

        live = 0;
        foreach (mq[i]) if (!mq[i].kill) live++;
        chk("pending_writes", 32'(live), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
